// File: rtl/ff_en_pipe.sv
// DEPTH-stage enabled data pipeline with per-stage valid, global stall, occupancy count
// and post-reset ready delay. Define FF_EN_PIPE_OUT_HOLD_EN to hold d_out through bubbles.
module ff_en_pipe #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned RDY_DELAY = 4
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       d_en,
    input  logic                       hold,
    output logic [WIDTH-1:0]           d_out,
    output logic                       d_vld,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       rdy
);

    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(RDY_DELAY + 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             advance;

    assign advance = rdy_q & ~hold;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q < CW'(RDY_DELAY)) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Sticky: rdy rises on the edge the count reaches RDY_DELAY and stays up.
        rdy_d = rdy_q | (cnt_d == CW'(RDY_DELAY));
    end

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        occ_d   = occ_q;
        if (advance) begin
            stage_d[0] = d_en ? d_in : '0;
            vld_d[0]   = d_en;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
            occ_d = occ_q + OW'(d_en) - OW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            vld_q <= '0;
            occ_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef FF_EN_PIPE_OUT_HOLD_EN
    logic [WIDTH-1:0] last_q, last_d;

    // Mux keeps d_out aligned with d_vld; the register only remembers the last valid word.
    always_comb begin
        last_d = vld_q[DEPTH-1] ? stage_q[DEPTH-1] : last_q;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign d_out = last_d;
`else
    assign d_out = stage_q[DEPTH-1];
`endif

    assign d_vld = vld_q[DEPTH-1];
    assign occ   = occ_q;
    assign rdy   = rdy_q;

endmodule

// File: tb/tb_ff_en_pipe.sv
// Scoreboard bench for ff_en_pipe (WIDTH=10, DEPTH=3, RDY_DELAY=4).
module tb_ff_en_pipe;

    localparam int unsigned WIDTH     = 10;
    localparam int unsigned DEPTH     = 3;
    localparam int unsigned RDY_DELAY = 4;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } ent_t;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic [WIDTH-1:0] d_in  = '0;
    logic             d_en  = 1'b0;
    logic             hold  = 1'b0;
    logic [WIDTH-1:0] d_out;
    logic             d_vld;
    logic [1:0]       occ;
    logic             rdy;

    ent_t             sb_q[$];
    int               edges;
    logic             rdy_m;
    logic [WIDTH-1:0] last_w;
    int               n_cmp = 0;
    int               n_err = 0;

    ff_en_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RDY_DELAY (RDY_DELAY)
    ) u_dut (
        .clock (clock),
        .rst   (rst),
        .d_in  (d_in),
        .d_en  (d_en),
        .hold  (hold),
        .d_out (d_out),
        .d_vld (d_vld),
        .occ   (occ),
        .rdy   (rdy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        ent_t             f;
        logic             ev;
        logic [WIDTH-1:0] ed;
        int               o;
        ev = 1'b0;
`ifdef FF_EN_PIPE_OUT_HOLD_EN
        ed = last_w;
`else
        ed = '0;
`endif
        o = 0;
        foreach (sb_q[i]) o += int'(sb_q[i].vld);
        if (sb_q.size() == DEPTH) begin
            f  = sb_q[0];
            ev = f.vld;
            if (f.vld) begin
                ed     = f.data;
                last_w = f.data;
            end
        end
        check_val("d_out", 32'(d_out), 32'(ed));
        check_val("d_vld", 32'(d_vld), 32'(ev));
        check_val("occ",   32'(occ),   32'(o));
        check_val("rdy",   32'(rdy),   32'(rdy_m));
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass, checks outputs.
    task automatic cycle(input logic en, input logic [WIDTH-1:0] din, input logic hd);
        ent_t e;
        d_en = en;
        d_in = din;
        hold = hd;
        @(posedge clock);
        if (!rst) begin
            if (rdy_m && !hd) begin
                e.vld  = en;
                e.data = en ? din : '0;
                sb_q.push_back(e);
                if (sb_q.size() > DEPTH) e = sb_q.pop_front();
            end
            edges++;
            if (edges >= RDY_DELAY) rdy_m = 1'b1;
        end
        #1;
        compare_outputs();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        sb_q.delete();
        edges  = 0;
        rdy_m  = 1'b0;
        last_w = '0;
        check_val("rst_d_out", 32'(d_out), 32'h0);
        check_val("rst_d_vld", 32'(d_vld), 32'h0);
        check_val("rst_occ",   32'(occ),   32'h0);
        check_val("rst_rdy",   32'(rdy),   32'h0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        // 1: reset, then d_en ignored while rdy is low
        apply_reset();
        repeat (RDY_DELAY) cycle(1'b1, 10'h123, 1'b0);
        check_val("rdy_after_delay", 32'(rdy), 32'h1);

        // 2: three back-to-back words, then drain
        cycle(1'b1, 10'h3FF, 1'b0);
        cycle(1'b1, 10'h155, 1'b0);
        cycle(1'b1, 10'h288, 1'b0);
        repeat (3) cycle(1'b0, 10'h000, 1'b0);

        // 3: single word followed by bubbles
        cycle(1'b1, 10'h155, 1'b0);
        repeat (3) cycle(1'b0, 10'h000, 1'b0);

        // 4: fill, then stall with a competing input
        cycle(1'b1, 10'h011, 1'b0);
        cycle(1'b1, 10'h022, 1'b0);
        cycle(1'b1, 10'h033, 1'b0);
        repeat (5) cycle(1'b1, 10'h0AA, 1'b1);

        // 5: steady stream while full
        for (int i = 0; i < 6; i++) cycle(1'b1, 10'(10'h200 + i), 1'b0);
        repeat (3) cycle(1'b0, 10'h000, 1'b0);

        // 6: reset with two words in flight
        cycle(1'b1, 10'h0F0, 1'b0);
        cycle(1'b1, 10'h00F, 1'b0);
        check_val("occ_before_rst", 32'(occ), 32'h2);
        apply_reset();
        repeat (RDY_DELAY + DEPTH + 1) cycle(1'b0, 10'h000, 1'b0);

        // Mixed random traffic
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        repeat (DEPTH + 1) cycle(1'b0, 10'h000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
